// File: rtl/option_packet_queue.sv
// Option packet FIFO feeding the Black-Scholes engine: buffers DEPTH packets, splits out
// the head's option type bit and holds REG_READY low for a fixed cooldown after each consume.
module option_packet_queue #(
  parameter int FIELD_W         = 32,
  parameter int NUM_FIELDS      = 6,
  parameter int DEPTH           = 4,
  parameter int COOLDOWN_CYCLES = 50,
  parameter int DROP_W          = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          BS_READY,
  input  logic [NUM_FIELDS*FIELD_W-1:0] FullPacket,
  output logic [NUM_FIELDS*FIELD_W-1:0] head_packet,
  output logic [FIELD_W-1:0]            otype,
  output logic                          hasUnusedData,
  output logic                          REG_READY,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          full,
  output logic [DROP_W-1:0]             drop_count,
  output logic                          state_dbg
);

  localparam int PKT_W    = NUM_FIELDS * FIELD_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int OCC_W    = PTR_W + 1;
  localparam int TYPE_BIT = (NUM_FIELDS - 1) * FIELD_W;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [7:0]       COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

  typedef enum logic {ST_READY, ST_COOLDOWN} state_t;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_next;
  state_t           state, state_next;
  logic [7:0]       cool_cnt;
  logic             prev_bs;
  logic             bs_rise, pop, push, drop;
  logic [PKT_W-1:0] head_raw;

  // Handshake: a rising edge on the BS_READY level is the consume request; it is honoured
  // only while REG_READY's underlying conditions hold (READY state, FIFO non-empty).
  assign bs_rise = BS_READY & ~prev_bs;
  assign pop     = bs_rise && (state == ST_READY) && (occ != '0);
  assign push    = en && ((occ != OCC_FULL) || pop);
  assign drop    = en && (occ == OCC_FULL) && !pop;

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + OCC_W'(1);
    else if (pop && !push) occ_next = occ - OCC_W'(1);
  end

  always_comb begin
    state_next = state;
    if (state == ST_READY) begin
      if (pop) state_next = ST_COOLDOWN;
    end else if (cool_cnt == COOL_LAST) begin
      state_next = ST_READY;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= FullPacket;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      state      <= ST_READY;
      cool_cnt   <= '0;
      prev_bs    <= 1'b0;
      REG_READY  <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_bs   <= BS_READY;
      occ       <= occ_next;
      state     <= state_next;
      REG_READY <= (occ_next != '0) && (state_next == ST_READY);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (state == ST_READY) cool_cnt <= '0;
      else                   cool_cnt <= cool_cnt + 8'd1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + DROP_W'(1);
    end
  end

  // Memory is not reset, so the head view is gated by non-empty to read zero after reset.
  assign head_raw = mem[rd_ptr];

  always_comb begin
    head_packet = '0;
    otype       = '0;
    if (occ != '0) begin
      head_packet           = head_raw;
      head_packet[TYPE_BIT] = 1'b0;
      otype[0]              = head_raw[TYPE_BIT];
    end
  end

  assign hasUnusedData = (occ != '0);
  assign occupancy     = occ;
  assign full          = (occ == OCC_FULL);
  assign state_dbg     = (state == ST_COOLDOWN);

endmodule

// File: doc/option_packet_queue.md
Name: option_packet_queue

Overview:
- Parametrised successor to the single-entry option packet register; feeds the Black-Scholes engine.
- Buffers up to DEPTH incoming option packets in a FIFO.
- Presents the head packet to the engine with its type bit split out.
- Enforces a programmable post-consume cooldown; sits between packet ingress and the pricing core.

Parameters:
FIELD_W, 32, width of each packet field in bits
NUM_FIELDS, 6, fields per packet; field NUM_FIELDS-1 (MSB) is opt_id, LSB of it is option type
DEPTH, 4, FIFO entries (power of two, >=2)
COOLDOWN_CYCLES, 50, cycles REG_READY held low after each consume (1..255)
DROP_W, 8, width of saturating drop counter

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-high reset
en  in  1  push strobe: capture FullPacket this cycle
BS_READY  in  1  engine ready level; its rising edge consumes head packet
FullPacket  in  NUM_FIELDS*FIELD_W  incoming packet, MSB field = opt_id/type word
head_packet  out  NUM_FIELDS*FIELD_W  head entry, bit 0 of opt_id field forced 0
otype  out  FIELD_W  {zeros, head type bit}
hasUnusedData  out  1  FIFO non-empty
REG_READY  out  1  head valid and not in cooldown (registered)
occupancy  out  $clog2(DEPTH)+1  entries held
full  out  1  occupancy==DEPTH
drop_count  out  DROP_W  pushes lost to full FIFO, saturating

Behaviour:
- Reset (async): FIFO pointers=0, occupancy=0, head_packet=0, otype=0, hasUnusedData=0, REG_READY=0, full=0, drop_count=0, prevBS_READY=0, state=READY, cooldown counter=0.
- Rise detect: bs_rise = BS_READY & ~prevBS_READY; prevBS_READY registered each cycle.
- Push: en=1 and (not full, or full with a pop this same cycle) -> write FullPacket at tail. en=1 while full with no pop -> packet dropped, drop_count+1 saturating at all-ones.
- Pop:
  - bs_rise while state=READY and occupancy>0 -> head removed.
  - bs_rise while empty or in COOLDOWN -> ignored; no pop, no state change.
- Simultaneous push and pop: occupancy unchanged; if empty, no pop occurs and push proceeds normally.
- head_packet/otype/hasUnusedData/occupancy/full reflect registered FIFO state; a push to an empty FIFO at edge N is visible after edge N.
- States:
  - READY -> COOLDOWN on a valid pop; cooldown counter cleared.
  - COOLDOWN: counter increments each cycle; returns to READY when counter reaches COOLDOWN_CYCLES-1.
  - Net effect: exactly COOLDOWN_CYCLES cycles spent in COOLDOWN.
- REG_READY register: next value = (next occupancy>0) && (next state==READY).
  - Low for the COOLDOWN_CYCLES cycles following a pop edge.
  - Then high iff data remains.
- Pointers wrap modulo DEPTH; occupancy is never >DEPTH and never <0.
- Reset mid-cooldown or mid-push: all state returns to reset values immediately; in-flight packet lost.
- en and BS_READY are synchronous inputs; no internal synchronisers.

Test Plan:
1. Reset, push one packet 0x12345679_3F800000_3F8CCCCD_40000000_40400000_40000000 -> next cycle head_packet opt_id field=0x12345678, otype=1, REG_READY=1, occupancy=1.
2. Pulse BS_READY (rise) with one entry -> REG_READY low for exactly 50 cycles, hasUnusedData=0, occupancy=0; REG_READY stays 0 after cooldown.
3. Push 3 packets, then consume one -> REG_READY returns high exactly 50 cycles after pop edge, head shows second packet; FIFO order preserved across all three.
4. Push 6 packets into DEPTH=4 -> full=1, occupancy=4, drop_count=2; head is first packet.
5. With full FIFO, en and bs_rise in same cycle -> occupancy stays 4, drop_count unchanged, new packet at tail.
6. Assert reset 20 cycles into cooldown with 2 entries -> all outputs 0 immediately; a push after reset gives REG_READY=1 next cycle with no residual cooldown.
